// File: rtl/gf_hash_pkg.sv
// Shared definitions for the GF(2^8) rolling-hash sequencer:
// the FSM state encoding, the lane width, and the byte multiplier.
package gf_hash_pkg;

  localparam int LANE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_MUL,
    ST_SQUASH,
    ST_SHIFT,
    ST_DONE
  } state_e;

  // Carry-less shift-and-add multiply. The multiplicand is doubled each
  // step and reduced by poly whenever its bit 7 shifts out.
  function automatic logic [LANE_W-1:0] gf_mul8(input logic [LANE_W-1:0] a,
                                                input logic [LANE_W-1:0] b,
                                                input logic [LANE_W-1:0] poly);
    logic [LANE_W-1:0] acc;
    logic [LANE_W-1:0] sh;
    logic              carry;
    acc = '0;
    sh  = a;
    for (int i = 0; i < LANE_W; i++) begin
      if (b[i]) acc = acc ^ sh;
      carry = sh[LANE_W-1];
      sh    = {sh[LANE_W-2:0], 1'b0};
      if (carry) sh = sh ^ poly;
    end
    return acc;
  endfunction

endpackage

// File: rtl/gf_hash_seq_if.sv
// Word-stream and hash-result handshakes of gf_hash_seq.
// slave = the sequencer side, master = front end / consumer side.
interface gf_hash_seq_if #(
  parameter int LANES = 8
);
  import gf_hash_pkg::*;

  localparam int DW = LANES * LANE_W;

  logic          in_valid_i;
  logic [DW-1:0] in_data_i;
  logic          in_ready_o;
  logic          out_valid_o;
  logic [DW-1:0] out_hash_o;
  logic          out_ready_i;

  modport slave (
    input  in_valid_i, in_data_i, out_ready_i,
    output in_ready_o, out_valid_o, out_hash_o
  );

  modport master (
    output in_valid_i, in_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_hash_o
  );

endinterface

// File: rtl/gf_lane_mul.sv
// One registered 8-bit GF(2^8) multiplier lane. The product register
// only loads when en_i is high so it holds between words.
module gf_lane_mul
  import gf_hash_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic [LANE_W-1:0] a_i,
  input  logic [LANE_W-1:0] b_i,
  input  logic [LANE_W-1:0] poly_i,
  output logic [LANE_W-1:0] p_o
);

  logic [LANE_W-1:0] p_d;
  logic [LANE_W-1:0] p_q;

  // Next product: new multiply when enabled, otherwise hold.
  always_comb begin
    p_d = p_q;
    if (en_i) p_d = gf_mul8(a_i, b_i, poly_i);
  end

  // Product register.
  always_ff @(posedge clk_i) begin
    if (rst_i) p_q <= '0;
    else       p_q <= p_d;
  end

  assign p_o = p_q;

endmodule

// File: rtl/gf_hash_seq.sv
// Rolling GF(2^8) hash sequencer: per word LOAD -> MUL -> SQUASH -> SHIFT,
// result presented in DONE. Optional abort input under GF_HASH_SEQ_ABORT_EN.
module gf_hash_seq
  import gf_hash_pkg::*;
#(
  parameter int LANES = 8,
  parameter int CNT_W = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [CNT_W-1:0]        num_words_i,
  input  logic [LANE_W-1:0]       poly_i,
  input  logic [LANES*LANE_W-1:0] coeff_i,
  input  logic [LANES*LANE_W-1:0] seed_i,
  gf_hash_seq_if.slave            bus,
`ifdef GF_HASH_SEQ_ABORT_EN
  input  logic                    abort_i,
`endif
  output logic                    busy_o
);

  localparam int DW = LANES * LANE_W;

  state_e            state_d, state_q;
  logic [LANE_W-1:0] poly_d, poly_q;
  logic [DW-1:0]     coeff_d, coeff_q;
  logic [DW-1:0]     hist_d, hist_q;
  logic [DW-1:0]     data_d, data_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic [LANE_W-1:0] sq_d, sq_q;
  logic              in_ready_d, in_ready_q;
  logic              out_valid_d, out_valid_q;
  logic              busy_d, busy_q;
  logic [DW-1:0]     prod;
  logic [LANE_W-1:0] sq_calc;
  logic              abort;

`ifdef GF_HASH_SEQ_ABORT_EN
  assign abort = abort_i;
`else
  assign abort = 1'b0;
`endif

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    gf_lane_mul u_mul (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .en_i   (state_q == ST_MUL),
      .a_i    (data_q[k*LANE_W +: LANE_W]),
      .b_i    (coeff_q[k*LANE_W +: LANE_W]),
      .poly_i (poly_q),
      .p_o    (prod[k*LANE_W +: LANE_W])
    );
  end

  // Squash: fold every lane product with its history byte down to one byte.
  always_comb begin
    sq_calc = '0;
    for (int k = 0; k < LANES; k++) begin
      sq_calc = sq_calc ^ prod[k*LANE_W +: LANE_W] ^ hist_q[k*LANE_W +: LANE_W];
    end
  end

  // Next-state and datapath updates; handshake outputs are precomputed
  // from the next state so they come straight off flops.
  always_comb begin
    state_d = state_q;
    poly_d  = poly_q;
    coeff_d = coeff_q;
    hist_d  = hist_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    sq_d    = sq_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          poly_d  = poly_i;
          coeff_d = coeff_i;
          cnt_d   = num_words_i;
          hist_d  = seed_i;
          state_d = (num_words_i == '0) ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (bus.in_valid_i) begin
          data_d  = bus.in_data_i;
          state_d = ST_MUL;
        end
      end
      ST_MUL:    state_d = ST_SQUASH;
      ST_SQUASH: begin
        sq_d    = sq_calc;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        hist_d  = {hist_q[DW-LANE_W-1:0], sq_q};
        cnt_d   = cnt_q - CNT_W'(1);
        state_d = (cnt_q == CNT_W'(1)) ? ST_DONE : ST_LOAD;
      end
      ST_DONE: begin
        if (bus.out_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Abort wins over any handshake and leaves the history untouched.
    if (abort && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      hist_d  = hist_q;
    end
    in_ready_d  = (state_d == ST_LOAD);
    out_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
  end

  // State, datapath and registered-output flops.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      poly_q      <= '0;
      coeff_q     <= '0;
      hist_q      <= '0;
      data_q      <= '0;
      cnt_q       <= '0;
      sq_q        <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      poly_q      <= poly_d;
      coeff_q     <= coeff_d;
      hist_q      <= hist_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      sq_q        <= sq_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready_o  = in_ready_q;
  assign bus.out_valid_o = out_valid_q;
  assign bus.out_hash_o  = hist_q;
  assign busy_o          = busy_q;

endmodule

// File: tb/tb_gf_hash_seq.sv
// Scoreboard bench for gf_hash_seq: the driver pushes the expected hash of
// each job, a negedge monitor pops and compares on every output handshake.
module tb_gf_hash_seq;
  import gf_hash_pkg::*;

  localparam int LANES = 8;
  localparam int CNT_W = 8;
  localparam int DW    = 64;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] num_words;
  logic [7:0]       poly;
  logic [DW-1:0]    coeff;
  logic [DW-1:0]    seed;
  logic             busy;
`ifdef GF_HASH_SEQ_ABORT_EN
  logic             abort;
`endif

  int checks   = 0;
  int failures = 0;
  logic [DW-1:0] exp_q[$];
  logic          prev_hold;
  logic [DW-1:0] prev_hash;

  always #5 clk = ~clk;

  gf_hash_seq_if #(.LANES(LANES)) bus ();

  gf_hash_seq #(.LANES(LANES), .CNT_W(CNT_W)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .num_words_i (num_words),
    .poly_i      (poly),
    .coeff_i     (coeff),
    .seed_i      (seed),
    .bus         (bus),
`ifdef GF_HASH_SEQ_ABORT_EN
    .abort_i     (abort),
`endif
    .busy_o      (busy)
  );

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pop/compare on each output handshake, and check that a
  // stalled result stays valid and unchanged.
  always @(negedge clk) begin
    if (rst) begin
      prev_hold <= 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_valid", {63'd0, bus.out_valid_o}, 64'd1);
        chk("hold_hash", bus.out_hash_o, prev_hash);
      end
      if (bus.out_valid_o && bus.out_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_hash: got %h expected no output", bus.out_hash_o);
        end else begin
          chk("hash", bus.out_hash_o, exp_q.pop_front());
        end
      end
      prev_hold <= bus.out_valid_o && !bus.out_ready_i;
      prev_hash <= bus.out_hash_o;
    end
  end

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 3000) begin
      @(posedge clk); #1;
      k++;
    end
    if (busy) chk("idle_timeout", 64'd1, 64'd0);
  endtask

  task automatic do_start(input logic [7:0] n, input logic [7:0] p, input logic [DW-1:0] c,
                          input logic [DW-1:0] s, input logic [DW-1:0] exp, input bit push);
    wait_idle();
    if (push) exp_q.push_back(exp);
    start = 1'b1; num_words = n; poly = p; coeff = c; seed = s;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Present one word (after optional stall cycles in LOAD); returns 1 time
  // unit after the accepting edge.
  task automatic send_word(input logic [DW-1:0] d, input int stall);
    int k;
    bus.in_valid_i = 1'b0;
    for (int i = 0; i < stall; i++) begin
      chk("stall_ready", {63'd0, bus.in_ready_o}, 64'd1);
      @(posedge clk); #1;
    end
    bus.in_valid_i = 1'b1;
    bus.in_data_i  = d;
    k = 0;
    while (!bus.in_ready_o && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    if (!bus.in_ready_o) chk("in_ready_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    bus.in_data_i  = 64'hDEAD_BEEF_DEAD_BEEF;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!bus.out_valid_o && k < 3000) begin
      @(posedge clk); #1;
      k++;
    end
    if (!bus.out_valid_o) chk("out_valid_timeout", 64'd0, 64'd1);
    else if (bus.out_ready_i) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic count_edges(input bit want_ready, output int lat);
    lat = 0;
    while (((want_ready ? bus.in_ready_o : bus.out_valid_o) == 1'b0) && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [DW-1:0] h;
    logic [7:0]    s;
    int            lat;
    rst = 1'b1; start = 1'b0; num_words = '0; poly = '0; coeff = '0; seed = '0;
    bus.in_valid_i = 1'b0; bus.in_data_i = '0; bus.out_ready_i = 1'b1;
`ifdef GF_HASH_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_in_ready", {63'd0, bus.in_ready_o}, 64'd0);
    chk("rst_out_valid", {63'd0, bus.out_valid_o}, 64'd0);
    chk("rst_hash", bus.out_hash_o, 64'd0);
    rst = 1'b0;

    // Single word: 0x57 * 0x83 = 0xC1; valid 3 edges after the accepting edge.
    do_start(8'd1, 8'h1B, 64'h83, 64'h0, 64'h0000_0000_0000_00C1, 1'b1);
    send_word(64'h57, 0);
    count_edges(1'b0, lat);
    chk("out_latency", 64'(lat), 64'd3);
    wait_done();

    // Two words: second squash cancels; next in_ready 3 edges after accept.
    do_start(8'd2, 8'h1B, 64'h83, 64'h0, 64'h0000_0000_0000_C100, 1'b1);
    send_word(64'h57, 0);
    count_edges(1'b1, lat);
    chk("in_ready_latency", 64'(lat), 64'd3);
    send_word(64'h57, 0);
    wait_done();

    // All lanes active with coeff 1; seed top byte drops off the history.
    do_start(8'd1, 8'h1B, 64'h0101_0101_0101_0101, 64'hFF00_0000_0000_0000,
             64'h0000_0000_0000_0077, 1'b1);
    send_word(64'h1122_3344_5566_7788, 0);
    wait_done();

    // Different polynomial on lane 3: 0x80 * 0x02 reduces to 0x1D.
    do_start(8'd1, 8'h1D, 64'h0000_0000_0200_0000, 64'h0, 64'h0000_0000_0000_001D, 1'b1);
    send_word(64'h0000_0000_8000_0000, 0);
    wait_done();

    // Zero-word job: DONE right after start, no word requested; then
    // start together with out_ready in DONE only returns to IDLE.
    do_start(8'd0, 8'h1B, 64'h0, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 1'b1);
    chk("zero_valid", {63'd0, bus.out_valid_o}, 64'd1);
    chk("zero_in_ready", {63'd0, bus.in_ready_o}, 64'd0);
    start = 1'b1; num_words = 8'd1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("done_start_busy", {63'd0, busy}, 64'd0);
    chk("done_start_valid", {63'd0, bus.out_valid_o}, 64'd0);
    @(posedge clk); #1;
    chk("done_start_ignored", {63'd0, busy}, 64'd0);

    // Input stall of 5 cycles, then output backpressure for 3 cycles.
    bus.out_ready_i = 1'b0;
    do_start(8'd1, 8'h1B, 64'h13, 64'h0, 64'h0000_0000_0000_00FE, 1'b1);
    send_word(64'h57, 5);
    wait_done();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", {63'd0, bus.out_valid_o}, 64'd1);
    end
    bus.out_ready_i = 1'b1;
    @(posedge clk); #1;

    // Reset during SQUASH abandons the job; a fresh job still works.
    do_start(8'd1, 8'h1B, 64'h83, 64'h0, 64'h0, 1'b0);
    send_word(64'h57, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_valid", {63'd0, bus.out_valid_o}, 64'd0);
    chk("midrst_hash", bus.out_hash_o, 64'd0);
    rst = 1'b0;
    do_start(8'd1, 8'h1B, 64'h83, 64'h0, 64'h0000_0000_0000_00C1, 1'b1);
    send_word(64'h57, 0);
    wait_done();

    // Maximum count: 255 words, lane 0 coeff 1 and data 0x01.
    h = '0;
    for (int w = 0; w < 255; w++) begin
      s = 8'h01;
      for (int k = 0; k < 8; k++) s = s ^ h[k*8 +: 8];
      h = {h[55:0], s};
    end
    do_start(8'd255, 8'h1B, 64'h01, 64'h0, h, 1'b1);
    for (int w = 0; w < 255; w++) send_word(64'h01, 0);
    wait_done();

`ifdef GF_HASH_SEQ_ABORT_EN
    // Abort in MUL: IDLE next cycle, no output; immediate restart accepted.
    do_start(8'd1, 8'h1B, 64'h83, 64'h0, 64'h0, 1'b0);
    send_word(64'h57, 0);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_valid", {63'd0, bus.out_valid_o}, 64'd0);
    do_start(8'd1, 8'h1B, 64'h83, 64'h0, 64'h0000_0000_0000_00C1, 1'b1);
    chk("abort_restart", {63'd0, busy}, 64'd1);
    send_word(64'h57, 0);
    wait_done();
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
